// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - registered ID/EX control unit with hazard bubbles, flush squash and
// optional multi-cycle MUL/DIV/MOD sequencing (compiled in when CTRL_MULTICYCLE_EN is defined).

`ifndef OP_NOP
`define OP_NOP  0
`define OP_ADD  1
`define OP_SUB  2
`define OP_MUL  3
`define OP_DIV  4
`define OP_MOD  5
`define OP_MOVR 6
`define OP_MOVI 7
`define OP_AND  8
`define OP_OR   9
`define OP_CMP  10
`define OP_LDR  11
`define OP_STR  12
`define OP_BEQ  13
`define OP_JMP  14
`endif

module ctrl_pipe_unit #(
  parameter int OP_W    = 4,
  parameter int EXE_W   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_code,
  input  logic             in_valid,
  input  logic             hazard_detected,
  input  logic             flush,
  output logic             ex_valid,
  output logic [EXE_W-1:0] exe_cmd,
  output logic [3:0]       branch_cmd,
  output logic             branch_en,
  output logic             is_imm,
  output logic             is_str,
  output logic             is_ldr,
  output logic             is_cmp,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             stall_out,
  output logic             mc_busy
);

  localparam logic [OP_W-1:0] K_ADD  = OP_W'(`OP_ADD);
  localparam logic [OP_W-1:0] K_SUB  = OP_W'(`OP_SUB);
  localparam logic [OP_W-1:0] K_MUL  = OP_W'(`OP_MUL);
  localparam logic [OP_W-1:0] K_DIV  = OP_W'(`OP_DIV);
  localparam logic [OP_W-1:0] K_MOD  = OP_W'(`OP_MOD);
  localparam logic [OP_W-1:0] K_MOVR = OP_W'(`OP_MOVR);
  localparam logic [OP_W-1:0] K_MOVI = OP_W'(`OP_MOVI);
  localparam logic [OP_W-1:0] K_AND  = OP_W'(`OP_AND);
  localparam logic [OP_W-1:0] K_OR   = OP_W'(`OP_OR);
  localparam logic [OP_W-1:0] K_CMP  = OP_W'(`OP_CMP);
  localparam logic [OP_W-1:0] K_LDR  = OP_W'(`OP_LDR);
  localparam logic [OP_W-1:0] K_STR  = OP_W'(`OP_STR);
  localparam logic [OP_W-1:0] K_BEQ  = OP_W'(`OP_BEQ);
  localparam logic [OP_W-1:0] K_JMP  = OP_W'(`OP_JMP);

  // Latencies outside 1..16 cannot be counted by the 4-bit cnt.
  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
    $error("MUL_LAT out of range 1..16");
  end
  if (DIV_LAT < 1 || DIV_LAT > 16) begin : g_bad_div_lat
    $error("DIV_LAT out of range 1..16");
  end

  typedef struct packed {
    logic             ex_valid;
    logic [EXE_W-1:0] exe_cmd;
    logic [3:0]       branch_cmd;
    logic             branch_en;
    logic             is_imm;
    logic             is_str;
    logic             is_ldr;
    logic             is_cmp;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
  } ctl_t;

  ctl_t dec;
  ctl_t ctl_d, ctl_q;

  // Decode the ID opcode into a control bundle; unknown opcodes become a bubble.
  always_comb begin
    dec          = '0;
    dec.ex_valid = 1'b1;
    unique case (op_code)
      K_ADD, K_SUB, K_MUL, K_DIV, K_MOD, K_MOVR, K_AND, K_OR: begin
        dec.exe_cmd = EXE_W'(op_code);
        dec.wb_en   = 1'b1;
      end
      K_MOVI: begin
        dec.exe_cmd = EXE_W'(op_code);
        dec.wb_en   = 1'b1;
        dec.is_imm  = 1'b1;
      end
      K_CMP: begin
        dec.exe_cmd = EXE_W'(op_code);
        dec.is_cmp  = 1'b1;
      end
      K_LDR: begin
        dec.exe_cmd  = EXE_W'(K_ADD);
        dec.wb_en    = 1'b1;
        dec.mem_r_en = 1'b1;
        dec.is_ldr   = 1'b1;
      end
      K_STR: begin
        dec.exe_cmd  = EXE_W'(K_ADD);
        dec.mem_w_en = 1'b1;
        dec.is_str   = 1'b1;
      end
      K_BEQ, K_JMP: begin
        dec.exe_cmd    = EXE_W'(op_code);
        dec.branch_cmd = 4'(op_code);
        dec.branch_en  = 1'b1;
      end
      default: dec = '0;
    endcase
  end

`ifdef CTRL_MULTICYCLE_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MULTI = 1'b1;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  logic [0:0] state_d, state_q;
  logic [3:0] cnt_d, cnt_q;

  // Next-state: in MULTI the EX op is older than any branch, so ID inputs are ignored.
  always_comb begin
    ctl_d   = ctl_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (flush || hazard_detected || !in_valid) begin
        ctl_d = '0;
      end else begin
        ctl_d = dec;
        if (op_code == K_MUL && MUL_LAT > 1) begin
          ctl_d.wb_en = 1'b0;
          cnt_d       = MUL_CNT;
          state_d     = MULTI;
        end else if ((op_code == K_DIV || op_code == K_MOD) && DIV_LAT > 1) begin
          ctl_d.wb_en = 1'b0;
          cnt_d       = DIV_CNT;
          state_d     = MULTI;
        end
      end
    end else begin
      if (cnt_q == 4'd1) begin
        ctl_d.wb_en = 1'b1;
        cnt_d       = 4'd0;
        state_d     = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mc_busy   = (state_q == MULTI);
  assign stall_out = (state_q == MULTI) || hazard_detected;
`else
  // Next-state: every op completes in one cycle.
  always_comb begin
    ctl_d = dec;
    if (flush || hazard_detected || !in_valid) begin
      ctl_d = '0;
    end
  end

  assign mc_busy   = 1'b0;
  assign stall_out = hazard_detected;
`endif

  // ID/EX control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign ex_valid   = ctl_q.ex_valid;
  assign exe_cmd    = ctl_q.exe_cmd;
  assign branch_cmd = ctl_q.branch_cmd;
  assign branch_en  = ctl_q.branch_en;
  assign is_imm     = ctl_q.is_imm;
  assign is_str     = ctl_q.is_str;
  assign is_ldr     = ctl_q.is_ldr;
  assign is_cmp     = ctl_q.is_cmp;
  assign wb_en      = ctl_q.wb_en;
  assign mem_r_en   = ctl_q.mem_r_en;
  assign mem_w_en   = ctl_q.mem_w_en;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - scoreboard bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DIV = 4'd4, MOD = 4'd5;
  localparam logic [3:0] MOVI = 4'd7, AND_ = 4'd8, OR_ = 4'd9, CMP = 4'd10, LDR = 4'd11;
  localparam logic [3:0] STR = 4'd12, BEQ = 4'd13, JMP = 4'd14, BAD = 4'd15;

  // flag order: branch_en, is_imm, is_str, is_ldr, is_cmp, wb_en, mem_r_en, mem_w_en
  localparam logic [7:0] F_BEN = 8'h80, F_IMM = 8'h40, F_STR = 8'h20, F_LDR = 8'h10;
  localparam logic [7:0] F_CMP = 8'h08, F_WB = 8'h04, F_MR = 8'h02, F_MW = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] op_code = 4'd0;
  logic       in_valid = 1'b0;
  logic       hazard_detected = 1'b0;
  logic       flush = 1'b0;
  logic       ex_valid;
  logic [3:0] exe_cmd;
  logic [3:0] branch_cmd;
  logic       branch_en, is_imm, is_str, is_ldr, is_cmp, wb_en, mem_r_en, mem_w_en;
  logic       stall_out, mc_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_step = 0;
  logic [18:0] sb_q[$];

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.OP_W(4), .EXE_W(4), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .in_valid(in_valid),
    .hazard_detected(hazard_detected), .flush(flush),
    .ex_valid(ex_valid), .exe_cmd(exe_cmd), .branch_cmd(branch_cmd),
    .branch_en(branch_en), .is_imm(is_imm), .is_str(is_str), .is_ldr(is_ldr),
    .is_cmp(is_cmp), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .stall_out(stall_out), .mc_busy(mc_busy)
  );

  function automatic logic [18:0] e(input logic ev, input logic [3:0] exe, input logic [3:0] br,
                                    input logic [7:0] f, input logic busy, input logic stall);
    return {ev, exe, br, f, busy, stall};
  endfunction

  // One cycle: drive inputs after the edge and queue what the outputs must show this cycle.
  task automatic step(input logic r, input logic [3:0] op, input logic v, input logic hz,
                      input logic fl, input logic [18:0] exp_v);
    @(posedge clk);
    #1;
    rst = r; op_code = op; in_valid = v; hazard_detected = hz; flush = fl;
    sb_q.push_back(exp_v);
  endtask

  // Monitor: compare the DUT outputs against the scoreboard at each falling edge.
  initial begin
    logic [18:0] got, want;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        want = sb_q.pop_front();
        got  = {ex_valid, exe_cmd, branch_cmd, branch_en, is_imm, is_str, is_ldr, is_cmp,
                wb_en, mem_r_en, mem_w_en, mc_busy, stall_out};
        n_chk++;
        n_step++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL ctl_out cycle %0d: got %b required %b", n_step, got, want);
        end
      end
    end
  end

  initial begin
    logic [18:0] z;
    z = 19'd0;
    // reset held with ADD presented
    step(1, ADD, 1, 0, 0, z);
    step(1, ADD, 1, 0, 0, z);
    step(0, ADD, 1, 0, 0, z);
    step(0, LDR, 1, 0, 0, e(1, ADD, 0, F_WB, 0, 0));
    // load-use hazard
    step(0, ADD, 1, 1, 0, e(1, ADD, 0, F_LDR | F_WB | F_MR, 0, 1));
    step(0, ADD, 1, 0, 0, z);
    step(0, JMP, 1, 0, 0, e(1, ADD, 0, F_WB, 0, 0));
    // branch flush
    step(0, SUB, 1, 0, 1, e(1, JMP, JMP, F_BEN, 0, 0));
    step(0, STR, 1, 0, 0, z);
    step(0, MOVI, 1, 0, 0, e(1, ADD, 0, F_STR | F_MW, 0, 0));
    step(0, CMP, 1, 0, 0, e(1, MOVI, 0, F_IMM | F_WB, 0, 0));
    step(0, BEQ, 1, 0, 0, e(1, CMP, 0, F_CMP, 0, 0));
    step(0, AND_, 0, 0, 0, e(1, BEQ, BEQ, F_BEN, 0, 0));
    step(0, BAD, 1, 0, 0, z);
    // simultaneous flush and hazard give one bubble
    step(0, OR_, 1, 1, 1, e(0, 0, 0, 0, 0, 1));
    step(0, OR_, 1, 0, 0, z);
    step(0, NOP, 0, 0, 0, e(1, OR_, 0, F_WB, 0, 0));
`ifdef CTRL_MULTICYCLE_EN
    // MUL, latency 3
    step(0, MUL, 1, 0, 0, z);
    step(0, OR_, 1, 0, 0, e(1, MUL, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MUL, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MUL, 0, F_WB, 0, 0));
    step(0, DIV, 1, 0, 0, e(1, OR_, 0, F_WB, 0, 0));
    // DIV, latency 8, flush+hazard at cnt=4 ignored
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, SUB, 1, 1, 1, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, F_WB, 0, 0));
    step(0, MOD, 1, 0, 0, e(1, OR_, 0, F_WB, 0, 0));
    // async reset at cnt=2 during a MOD op
    step(0, OR_, 1, 0, 0, e(1, MOD, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MOD, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MOD, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MOD, 0, 0, 1, 1));
    step(0, OR_, 1, 0, 0, e(1, MOD, 0, 0, 1, 1));
    step(1, OR_, 1, 0, 0, z);
    step(0, OR_, 1, 0, 0, z);
    step(0, NOP, 0, 0, 0, e(1, OR_, 0, F_WB, 0, 0));
`else
    // single-cycle MUL/DIV
    step(0, DIV, 1, 0, 0, z);
    step(0, OR_, 1, 0, 0, e(1, DIV, 0, F_WB, 0, 0));
    step(0, MUL, 1, 0, 0, e(1, OR_, 0, F_WB, 0, 0));
    step(0, NOP, 0, 0, 0, e(1, MUL, 0, F_WB, 0, 0));
`endif
    // drain the scoreboard, bounded
    begin
      int waited;
      waited = 0;
      while (sb_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      n_chk++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
